// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The execute stage is the master; the divider is the slave.
interface div_unit_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_data1;
  logic [31:0] div_data2;
  logic        flush;
  logic        div_done;
  logic [63:0] div_result;

  modport master (
    output div_start, div_signed, div_data1, div_data2, flush,
    input  div_done, div_result
  );

  modport slave (
    input  div_start, div_signed, div_data1, div_data2, flush,
    output div_done, div_result
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring radix-2 divider, signed/unsigned; done pulses 33 cycles after start (1 for /0).
// Requester holds div_start until div_done; dropping it or flushing mid-divide aborts silently.
module div_unit (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        sgn;
  logic        q_neg;
  logic        r_neg;
  logic [63:0] result;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] rem_nxt;
  logic [31:0] quot_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign abs1 = (bus.div_signed && bus.div_data1[31]) ? -bus.div_data1 : bus.div_data1;
  assign abs2 = (bus.div_signed && bus.div_data2[31]) ? -bus.div_data2 : bus.div_data2;

  // One restoring step; trial[32] set means the subtraction underflowed.
  assign rem_sh   = {rem, quot[31]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign rem_nxt  = trial[32] ? rem_sh[31:0] : trial[31:0];
  assign quot_nxt = {quot[30:0], ~trial[32]};

  assign q_fix = (sgn && q_neg) ? -quot_nxt : quot_nxt;
  assign r_fix = (sgn && r_neg) ? -rem_nxt  : rem_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      quot   <= 32'd0;
      rem    <= 32'd0;
      dvs    <= 32'd0;
      sgn    <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.div_start && !bus.flush) begin
            sgn   <= bus.div_signed;
            quot  <= abs1;
            rem   <= 32'd0;
            dvs   <= abs2;
            q_neg <= bus.div_data1[31] ^ bus.div_data2[31];
            r_neg <= bus.div_data1[31];
            cnt   <= 6'd0;
            // Divide by zero bypasses the iteration: all-ones quotient, dividend as remainder.
            if (bus.div_data2 == 32'd0) begin
              result <= {bus.div_data1, 32'hFFFF_FFFF};
              state  <= DONE;
            end else begin
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush || !bus.div_start) begin
            state <= IDLE;
          end else begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result <= {r_fix, q_fix};
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.div_done   = (state == DONE);
  assign bus.div_result = result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against a plain-arithmetic division model.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] last_res = 64'h0;

  always #5 clk = ~clk;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle (cycle 0) and follows it to div_done.
  // hold=1 keeps div_start high through DONE and drops it in the following cycle.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input string tag);
    logic [63:0] exp;
    int lat, want, extra;
    bit changed;
    exp  = ref_div(sgn, a, b);
    want = (b == 32'd0) ? 1 : 33;
    bus.div_signed = sgn;
    bus.div_data1  = a;
    bus.div_data2  = b;
    bus.flush      = 1'b0;
    bus.div_start  = 1'b1;
    lat = -1;
    changed = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      bus.div_data1  = 32'($urandom);
      bus.div_data2  = 32'($urandom);
      bus.div_signed = 1'($urandom);
      if (bus.div_done) lat = c;
      else if (bus.div_result !== last_res) changed = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(want));
    check({tag, "_res"}, bus.div_result, exp);
    check({tag, "_hold_before"}, 64'(changed), 64'd0);
    last_res = exp;
    if (hold) begin
      tick();
      check({tag, "_pulse"}, 64'(bus.div_done), 64'd0);
      bus.div_start = 1'b0;
      extra = 0;
      repeat (5) begin
        tick();
        if (bus.div_done) extra++;
      end
      check({tag, "_no_redo"}, 64'(extra), 64'd0);
      check({tag, "_res_hold"}, bus.div_result, exp);
    end else begin
      bus.div_start = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] a, b;
    int  early, lat;
    bit  changed;

    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_data1  = 32'd0;
    bus.div_data2  = 32'd0;
    bus.flush      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 64'(bus.div_done), 64'd0);
    check("rst_result", bus.div_result, 64'h0);
    rst = 1'b1;
    tick();

    run_op(1'b0, 32'd100, 32'd7, 1'b1, "u100_7");
    check("u100_7_const", bus.div_result, {32'd2, 32'd14});

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
    check("s_m7_2_const", bus.div_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    check("s_ovf_const", bus.div_result, {32'h0, 32'h8000_0000});

    run_op(1'b1, 32'h1234_5678, 32'd0, 1'b1, "s_div0");
    check("s_div0_const", bus.div_result, {32'h1234_5678, 32'hFFFF_FFFF});
    run_op(1'b1, 32'h8765_4321, 32'd0, 1'b1, "s_div0_neg");
    run_op(1'b0, 32'h1234_5678, 32'd0, 1'b1, "u_div0");
    check("u_div0_const", bus.div_result, {32'h1234_5678, 32'hFFFF_FFFF});

    // Flush in cycle 10, new 20/6 in cycle 12, done expected in cycle 45.
    bus.div_signed = 1'b0;
    bus.div_data1  = 32'hFFFF_FFFF;
    bus.div_data2  = 32'd3;
    bus.div_start  = 1'b1;
    early = 0;
    changed = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c <= 44 && bus.div_done) early++;
      if (c <= 44 && bus.div_result !== last_res) changed = 1'b1;
      if (c == 10) bus.flush = 1'b1;
      if (c == 11) begin bus.flush = 1'b0; bus.div_start = 1'b0; end
      if (c == 12) begin
        bus.div_start = 1'b1;
        bus.div_data1 = 32'd20;
        bus.div_data2 = 32'd6;
      end
    end
    check("flush_no_done", 64'(early), 64'd0);
    check("flush_res_hold", 64'(changed), 64'd0);
    check("flush_new_done", 64'(bus.div_done), 64'd1);
    check("flush_new_res", bus.div_result, {32'd2, 32'd3});
    last_res = {32'd2, 32'd3};
    tick();
    bus.div_start = 1'b0;
    check("flush_new_pulse", 64'(bus.div_done), 64'd0);
    tick();

    // Flush in IDLE blocks the start; the op begins one cycle later instead.
    bus.div_signed = 1'b0;
    bus.div_data1  = 32'd77;
    bus.div_data2  = 32'd5;
    bus.div_start  = 1'b1;
    bus.flush      = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      bus.flush = 1'b0;
      if (bus.div_done) lat = c;
    end
    check("idle_flush_lat", 64'(lat), 64'd34);
    check("idle_flush_res", bus.div_result, ref_div(1'b0, 32'd77, 32'd5));
    last_res = ref_div(1'b0, 32'd77, 32'd5);
    bus.div_start = 1'b0;
    tick();

    // Dropping div_start during BUSY aborts without a done pulse.
    bus.div_data1 = 32'd999;
    bus.div_data2 = 32'd13;
    bus.div_start = 1'b1;
    early = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 6) bus.div_start = 1'b0;
      if (bus.div_done) early++;
    end
    check("abort_no_done", 64'(early), 64'd0);
    check("abort_res_hold", bus.div_result, last_res);

    // Back-to-back: drop start in DONE, restart in the next IDLE cycle.
    run_op(1'b0, 32'd1000, 32'd10, 1'b0, "b2b_first");
    tick();
    run_op(1'b0, 32'd9, 32'd4, 1'b1, "b2b_second");
    check("b2b_const", bus.div_result, {32'd1, 32'd2});

    for (int i = 0; i < 24; i++) begin
      a = 32'($urandom);
      case (i % 4)
        0: b = 32'($urandom);
        1: b = 32'($urandom_range(1, 16));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = (i == 7) ? 32'd0 : 32'($urandom) >> $urandom_range(0, 31);
      endcase
      run_op(1'($urandom), a, b, 1'($urandom), $sformatf("rnd%0d", i));
      if (bus.div_start == 1'b0 && !bus.div_done) tick();
      else begin bus.div_start = 1'b0; tick(); end
    end

    // Reset pulsed mid-operation.
    run_op(1'b0, 32'd50, 32'd7, 1'b1, "pre_rst");
    bus.div_data1 = 32'hDEAD_BEEF;
    bus.div_data2 = 32'd3;
    bus.div_start = 1'b1;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_done", 64'(bus.div_done), 64'd0);
    check("midrst_result", bus.div_result, 64'h0);
    bus.div_start = 1'b0;
    #2 rst = 1'b1;
    last_res = 64'h0;
    early = 0;
    changed = 1'b0;
    repeat (50) begin
      tick();
      if (bus.div_done) early++;
      if (bus.div_result !== 64'h0) changed = 1'b1;
    end
    check("postrst_no_done", 64'(early), 64'd0);
    check("postrst_res_zero", 64'(changed), 64'd0);

    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, "post_rst_op");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: div_start  input  1  request from ex, held high until div_done is seen.
REQ-005 Port: div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
REQ-006 Port: div_data1  input  32  dividend.
REQ-007 Port: div_data2  input  32  divisor.
REQ-008 Port: flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 Port: div_done  output  1  result valid, one-cycle pulse.
REQ-010 Port: div_result  output  64  {remainder[63:32], quotient[31:0]}.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-012 In IDLE with div_start=1 and flush=0, the block SHALL latch div_signed, |div_data1| and |div_data2| (absolute values only when signed), the quotient sign (data1[31]^data2[31]) and the remainder sign (data1[31]).
REQ-013 On that same edge it SHALL clear the 6-bit iteration counter and go to BUSY, except that a zero divisor SHALL go directly to DONE.
REQ-014 Each BUSY cycle SHALL perform one restoring radix-2 step:
  - shift {rem, quot} left by 1;
  - trial = rem[32:0] - {1'b0, divisor};
  - if trial is non-negative, rem = trial and the quotient LSB is 1.
REQ-015 After the 32nd step, BUSY SHALL go to DONE.
REQ-016 Latency: counting the first IDLE cycle with div_start=1 as cycle 0, div_done SHALL be high in cycle 33 (cycle 1 for a zero divisor).
REQ-017 In DONE, div_done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-018 A div_start that is still high during DONE SHALL NOT start a new operation; a new start is sampled only in IDLE.
REQ-019 Signed correction in DONE:
  - quotient negated if the quotient sign is 1;
  - remainder negated if the remainder sign is 1.
REQ-020 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0 without special casing.
REQ-021 Divisor zero SHALL give quotient 0xFFFFFFFF and remainder = the original div_data1, in both signed and unsigned mode.
REQ-022 Operand inputs SHALL be ignored outside the IDLE start cycle.
REQ-023 flush=1, or div_start=0 while in BUSY, SHALL return the FSM to IDLE on the next edge with no div_done pulse.
  - flush has priority over all other transitions.
  - flush in IDLE blocks a start in that cycle.
REQ-024 div_result SHALL be updated only when entering DONE and SHALL hold its value otherwise.
REQ-025 div_done SHALL be 0 in all states other than DONE.

Reset
REQ-026 While rst=0, the block SHALL hold these values, asynchronously and independent of clk:
  - state IDLE;
  - div_done 0;
  - div_result 64'h0;
  - counter 0;
  - internal operand and sign registers 0.
REQ-027 Reset asserted mid-operation SHALL discard that operation; after release, no div_done SHALL occur until a new div_start is sampled in IDLE.

Verification
REQ-028 Unsigned 100/7 with start held -> div_done only in cycle 33, div_result = {32'd2, 32'd14}; start dropped in cycle 34 -> FSM in IDLE, no second done.
REQ-029 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-030 Divide by zero, 0x12345678 / 0 (signed and unsigned) -> div_done in cycle 1, div_result = {0x12345678, 0xFFFFFFFF}.
REQ-031 Unsigned 0xFFFFFFFF/3 with flush=1 in cycle 10 -> no div_done through cycle 40; a new start 20/6 in cycle 12 -> div_done in cycle 45 with {2, 3}; div_result still holds the pre-flush value in cycles 13-44.
REQ-032 Reset pulsed low in cycle 5 of an operation -> div_done and div_result read 0 immediately; with start low after release, no div_done ever occurs.
REQ-033 Back-to-back: start dropped in the DONE cycle and raised again in the following IDLE cycle with 9/4 -> second div_done exactly 33 cycles later with {1, 2}.
